// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and blanking masks for the stopwatch controller
package stopwatch_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSED  = 2'd1,
        ADJ_SEC = 2'd2,
        ADJ_MIN = 2'd3
    } sw_state_t;
    localparam logic [3:0] BLANK_MIN  = 4'b1100;
    localparam logic [3:0] BLANK_SEC  = 4'b0011;
    localparam logic [3:0] BLANK_NONE = 4'b0000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and press pulse for a raw push-button
// Ports: MegaClk/reset (sync, active-high); btn_raw asynchronous button;
//        btn_level debounced level; btn_press one-cycle pulse on a debounced 0->1.
module btn_debounce #(
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic MegaClk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);
    logic        sync_a, sync_b, level_q;
    logic [23:0] cnt;
    always_ff @(posedge MegaClk) begin
        if (reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            btn_level <= 1'b0;
            level_q   <= 1'b0;
            btn_press <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_a    <= btn_raw;
            sync_b    <= sync_a;
            level_q   <= btn_level;
            btn_press <= btn_level & ~level_q;
            // The level only flips after DEB_CYCLES consecutive disagreeing samples.
            if (sync_b == btn_level) begin
                cnt <= '0;
            end else if (cnt == 24'(DEB_CYCLES - 1)) begin
                btn_level <= sync_b;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 24'd1;
            end
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: RUN/PAUSED/ADJ mode FSM driving count strobes and digit blanking
// Ports: MegaClk/reset (sync, active-high); pause_btn raw button; adj/sel adjust controls;
//        clk_1hz/clk_2hz/clk_blink square waves; cnt_inc/sec_inc/min_inc strobes;
//        blank_mask per-digit blank; state current mode; paused saved pause flag.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic       MegaClk,
    input  logic       reset,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       clk_blink,
    output logic       cnt_inc,
    output logic       sec_inc,
    output logic       min_inc,
    output logic [3:0] blank_mask,
    output sw_state_t  state,
    output logic       paused
);
    logic      press, btn_level_unused;
    logic      lvl_1hz, prev_1hz, lvl_2hz, prev_2hz, blink_ph;
    logic      rise_1hz, rise_2hz;
    sw_state_t state_n;
    logic      paused_n;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .MegaClk  (MegaClk),
        .reset    (reset),
        .btn_raw  (pause_btn),
        .btn_level(btn_level_unused),
        .btn_press(press)
    );

    assign rise_1hz = lvl_1hz & ~prev_1hz;
    assign rise_2hz = lvl_2hz & ~prev_2hz;

    always_comb begin
        state_n  = state;
        paused_n = paused;
        if (adj) begin
            state_n = sel ? ADJ_MIN : ADJ_SEC;
        end else if (state == ADJ_SEC || state == ADJ_MIN) begin
            state_n = paused ? PAUSED : RUN;
        end else if (press) begin
            state_n  = (state == RUN) ? PAUSED : RUN;
            paused_n = (state == RUN);
        end
    end

    // Edge registers track the input during reset so a wave already high at release is not a rise.
    always_ff @(posedge MegaClk) begin
        lvl_1hz  <= clk_1hz;
        lvl_2hz  <= clk_2hz;
        prev_1hz <= reset ? clk_1hz : lvl_1hz;
        prev_2hz <= reset ? clk_2hz : lvl_2hz;
        blink_ph <= clk_blink;
    end

    always_ff @(posedge MegaClk) begin
        if (reset) begin
            state      <= RUN;
            paused     <= 1'b0;
            cnt_inc    <= 1'b0;
            sec_inc    <= 1'b0;
            min_inc    <= 1'b0;
            blank_mask <= BLANK_NONE;
        end else begin
            state      <= state_n;
            paused     <= paused_n;
            cnt_inc    <= rise_1hz & (state == RUN);
            sec_inc    <= rise_2hz & (state == ADJ_SEC);
            min_inc    <= rise_2hz & (state == ADJ_MIN);
            blank_mask <= blink_ph ? BLANK_NONE :
                          (state == ADJ_SEC) ? BLANK_MIN :
                          (state == ADJ_MIN) ? BLANK_SEC : BLANK_NONE;
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed vector bench for stopwatch_ctrl with DEB_CYCLES=4
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic       MegaClk, reset, pause_btn, adj, sel, clk_1hz, clk_2hz, clk_blink;
    logic       cnt_inc, sec_inc, min_inc, paused;
    logic [3:0] blank_mask;
    sw_state_t  state;
    int         n_tests = 0;
    int         n_fail  = 0;

    typedef struct packed {
        logic       adj, sel, c2, bl;
        logic       e_sec, e_min;
        logic [3:0] e_mask;
        logic [1:0] e_state;
        logic       e_paused;
    } vec_t;
    vec_t tbl [12];

    stopwatch_ctrl #(.DEB_CYCLES(4)) dut (
        .MegaClk   (MegaClk),
        .reset     (reset),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .clk_1hz   (clk_1hz),
        .clk_2hz   (clk_2hz),
        .clk_blink (clk_blink),
        .cnt_inc   (cnt_inc),
        .sec_inc   (sec_inc),
        .min_inc   (min_inc),
        .blank_mask(blank_mask),
        .state     (state),
        .paused    (paused)
    );

    initial MegaClk = 1'b0;
    always #5 MegaClk = ~MegaClk;

    task automatic step();
        @(negedge MegaClk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] st(input sw_state_t s);
        return {6'd0, s};
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 2'd2, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 2'd2, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 2'd3, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 2'd3, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 2'd3, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};

        reset = 1'b1; pause_btn = 1'b0; adj = 1'b0; sel = 1'b0;
        clk_1hz = 1'b1; clk_2hz = 1'b0; clk_blink = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Reset release with clk_1hz high, then 1 Hz ticks of period 10
        for (int c = 0; c < 40; c++) begin
            clk_1hz = (c % 10) < 5;
            step();
            if (c == 0) begin
                check("reset_state", st(state), st(RUN));
                check("reset_mask", {4'd0, blank_mask}, 8'd0);
                check("reset_paused", {7'd0, paused}, 8'd0);
            end
            check("tick", {7'd0, cnt_inc}, {7'd0, (c >= 10 && c % 10 == 1)});
        end

        // Bounce shorter than the debounce window
        for (int b = 0; b < 20; b++) begin
            pause_btn = ((b / 2) % 2) == 0;
            step();
            check("bounce_state", st(state), st(RUN));
        end
        // Stable press: PAUSED on the 8th cycle of the hold
        for (int h = 0; h < 10; h++) begin
            pause_btn = 1'b1;
            step();
            check("press_state", st(state), st(h >= 7 ? PAUSED : RUN));
        end
        check("press_paused", {7'd0, paused}, 8'd1);
        for (int c = 0; c < 20; c++) begin
            clk_1hz = (c % 10) < 5;
            step();
            check("paused_no_tick", {7'd0, cnt_inc}, 8'd0);
        end
        for (int c = 0; c < 10; c++) begin
            pause_btn = 1'b0;
            step();
        end
        check("release_state", st(state), st(PAUSED));

        // Adjust entry/exit and blink mask
        for (int i = 0; i < 12; i++) begin
            adj = tbl[i].adj; sel = tbl[i].sel; clk_2hz = tbl[i].c2; clk_blink = tbl[i].bl;
            step();
            check($sformatf("adj%0d_state", i), st(state), {6'd0, tbl[i].e_state});
            check($sformatf("adj%0d_sec", i), {7'd0, sec_inc}, {7'd0, tbl[i].e_sec});
            check($sformatf("adj%0d_min", i), {7'd0, min_inc}, {7'd0, tbl[i].e_min});
            check($sformatf("adj%0d_mask", i), {4'd0, blank_mask}, {4'd0, tbl[i].e_mask});
            check($sformatf("adj%0d_paused", i), {7'd0, paused}, {7'd0, tbl[i].e_paused});
            check($sformatf("adj%0d_cnt", i), {7'd0, cnt_inc}, 8'd0);
        end

        // Press from PAUSED back to RUN
        for (int h = 0; h < 10; h++) begin
            pause_btn = 1'b1;
            step();
            check("resume_state", st(state), st(h >= 7 ? RUN : PAUSED));
        end
        check("resume_paused", {7'd0, paused}, 8'd0);
        for (int c = 0; c < 10; c++) begin
            pause_btn = 1'b0;
            step();
        end

        // Press and 1 Hz rise land together in RUN
        for (int h = 0; h < 10; h++) begin
            pause_btn = 1'b1;
            clk_1hz = (h >= 6);
            step();
            check("simul_cnt", {7'd0, cnt_inc}, {7'd0, (h == 7)});
            check("simul_state", st(state), st(h >= 7 ? PAUSED : RUN));
        end
        for (int c = 0; c < 10; c++) begin
            pause_btn = 1'b0;
            clk_1hz = 1'b0;
            step();
        end

        // Reset in the middle of a debounce
        for (int h = 0; h < 4; h++) begin
            pause_btn = 1'b1;
            step();
            check("middeb_state", st(state), st(PAUSED));
        end
        reset = 1'b1;
        pause_btn = 1'b0;
        step();
        check("rst_state", st(state), st(RUN));
        check("rst_paused", {7'd0, paused}, 8'd0);
        check("rst_mask", {4'd0, blank_mask}, 8'd0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            check("post_rst_state", st(state), st(RUN));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller for the MM:SS stopwatch. Debounces the pause button, turns the free-running clock-generator square waves into single-cycle strobes and runs the RUN/PAUSED/ADJ_SEC/ADJ_MIN state machine. Drives the digit counter with increment strobes and the display path with a digit blanking mask. It replaces the ad-hoc guard-bit logic in the top level, leaving the counter as a pure datapath.

## Interface
- DEB_CYCLES, 2_000_000: consecutive stable MegaClk cycles required before the debounced pause level changes; legal range 1 to 2^24-1.
- MegaClk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pause_btn  in  1  raw pause push-button, asynchronous to MegaClk.
- adj  in  1  adjust-mode switch (level).
- sel  in  1  adjust field select: 0 = seconds, 1 = minutes.
- clk_1hz  in  1  1 Hz square wave from Clock, in the MegaClk domain.
- clk_2hz  in  1  2 Hz square wave from Clock, in the MegaClk domain.
- clk_blink  in  1  blink square wave from Clock, in the MegaClk domain.
- cnt_inc  out  1  one-cycle strobe: increment the full MM:SS count, with carry and 99:59→00:00 wrap.
- sec_inc  out  1  one-cycle strobe: increment the seconds field only (59→00, no carry).
- min_inc  out  1  one-cycle strobe: increment the minutes field only (99→00).
- blank_mask  out  4  per-digit blank; bit0 = seconds ones … bit3 = minutes tens; 1 = all segments off.
- state  out  2  current sw_state_t, for debug and LEDs.
- paused  out  1  saved pause flag.

## Operation
- **pause_btn synchroniser:** 2-FF synchroniser.
- **Debounce counter:**
  - Counts while the synchronised input differs from the debounced level.
  - Clears whenever the two are equal.
  - When it reaches DEB_CYCLES, the debounced level takes the new value and the counter clears.
- **press:** one-cycle pulse on a 0→1 transition of the debounced level.
- **Edge detectors:**
  - rise_1hz, rise_2hz = level & ~prev.
  - blink_ph = registered clk_blink.
- **State machine:** states RUN, PAUSED, ADJ_SEC, ADJ_MIN.
  - Saved flag `paused` records RUN vs PAUSED across adjust mode.
- **Transitions (priority order):**
  - adj=1, sel=0 → ADJ_SEC.
  - adj=1, sel=1 → ADJ_MIN. A sel change while in an ADJ state switches field on the next cycle.
  - adj=0 in an ADJ state → PAUSED if paused=1, else RUN.
  - RUN + press → PAUSED, paused←1.
  - PAUSED + press → RUN, paused←0.
  - press in an ADJ state is ignored; paused is unchanged.
- **Strobes:** decoded from the current registered state, not the next state.
  - cnt_inc = rise_1hz & (state==RUN).
  - sec_inc = rise_2hz & (state==ADJ_SEC).
  - min_inc = rise_2hz & (state==ADJ_MIN).
  - At most one strobe is high in any cycle.
- **blank_mask:**
  - ADJ_SEC with blink_ph=0 → 4'b1100.
  - ADJ_MIN with blink_ph=0 → 4'b0011.
  - All other cases → 4'b0000.

## Timing
- **Reset values:**
  - state=RUN, paused=0, all strobes 0, blank_mask=0.
  - Debounced level 0, debounce counter 0, synchroniser FFs 0.
- **Edge registers:** during reset, prev_1hz/prev_2hz load the current input level. A square wave that is already high at reset release therefore produces no strobe.
- **Strobe latency:** if clk_1hz is first sampled high at edge N, cnt_inc is high for exactly the cycle after edge N+1 (registered output, one cycle wide). sec_inc and min_inc follow the same rule on clk_2hz.
- **Press latency:**
  - 2 cycles of synchroniser, then DEB_CYCLES stable cycles, then 1 cycle to press, then 1 cycle to the state change.
  - Bounces shorter than DEB_CYCLES never change the level.
- **state / paused:** registered; visible the cycle after the transition condition.
- **blank_mask:** registered; follows blink_ph and state with 1 cycle of latency.
- **Simultaneous events:**
  - press and rise_1hz in RUN: cnt_inc fires and the state still becomes PAUSED.
  - adj rising with rise_1hz: cnt_inc fires from RUN.
  - adj falling with rise_2hz: the field strobe fires from the ADJ state.
- **Reset mid-debounce or mid-adjust:** everything returns to reset values the next cycle; a pending press is discarded.

## Structure
- **Package stopwatch_pkg:**
  - typedef enum logic [1:0] sw_state_t {RUN=0, PAUSED=1, ADJ_SEC=2, ADJ_MIN=3}.
  - Constants BLANK_MIN=4'b1100, BLANK_SEC=4'b0011, BLANK_NONE=4'b0000.
- **Sub-module btn_debounce:**
  - Parameter DEB_CYCLES.
  - Ports MegaClk, reset, btn_raw, btn_level, btn_press.
  - Holds the synchroniser, the counter and the rising-edge pulse.
- **Top of stopwatch_ctrl:** edge detectors, FSM, strobe/mask registers.

## Test plan
All directed tests use DEB_CYCLES=4.
1. **Reset:** hold reset 3 cycles with clk_1hz=1, then release → state=RUN, blank_mask=0, and no cnt_inc until clk_1hz goes 0 and then 1.
2. **Run ticks:** toggle clk_1hz with period 10 → one cnt_inc pulse per period, each 1 cycle wide, 2 cycles after the sampled rise edge.
3. **Debounce:**
   - pause_btn bouncing 1/0 every 2 cycles for 20 cycles → no state change.
   - Then held high for 10 cycles → state=PAUSED exactly 8 cycles after the hold starts (2 sync + 4 stable + press + state); cnt_inc stops.
4. **Adjust entry/exit:**
   - From PAUSED, adj=1, sel=0 → ADJ_SEC; clk_2hz rises → sec_inc pulses.
   - sel=1 → ADJ_MIN; min_inc pulses on the next rise.
   - adj=0 → PAUSED, paused=1.
5. **Blink mask:** in ADJ_SEC with clk_blink=0 → blank_mask=4'b1100; with clk_blink=1 → 4'b0000. In ADJ_MIN with clk_blink=0 → 4'b0011.
6. **Simultaneous events:**
   - press and clk_1hz rise in the same cycle in RUN → one cnt_inc, then state=PAUSED.
   - reset asserted mid-debounce → state=RUN and no press generated afterwards.
